// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from one 52-card deck and
//   delivers each card's blackjack value to the player or dealer hand.
// Latency: a request in IDLE leads to SEARCH (1..52 cycles), then PRESENT
//   (1 cycle), then a one-cycle STROBE. An opening deal repeats this four
//   times, with a GAP cycle between draws.
// Backpressure: none. All requests, including shuffle, are ignored while
//   o_busy is high. Deal and hit requests are dropped when the deck is empty.
//
// Ports:
//   i_clk, i_reset_n     clock (rising edge) and async active-low reset
//   i_shuffle            return all cards to the deck and reload the LFSR
//   i_deal_start         4-card opening deal: player, dealer, player, dealer
//   i_hit_player/dealer  deal a single card to one hand
//   o_new_card           value of the card being delivered; held until the next draw
//   o_add_player/dealer  one-cycle add-card strobes
//   o_busy               high in every state except IDLE
//   o_deck_empty         high when no cards remain
//   o_cards_remaining    number of undealt cards, 0..52
//
// Build option: define STACKED_DECK_EN to bypass the LFSR. Every draw then
// starts its probe at slot 0, so cards come out in index order.

module card_dealer #(
  parameter int         CARD_W    = 5,
  parameter logic [6:0] LFSR_SEED = 7'h5A
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_shuffle,
  input  logic              i_deal_start,
  input  logic              i_hit_player,
  input  logic              i_hit_dealer,
  output logic [CARD_W-1:0] o_new_card,
  output logic              o_add_player,
  output logic              o_add_dealer,
  output logic              o_busy,
  output logic              o_deck_empty,
  output logic [5:0]        o_cards_remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_PRESENT,
    S_STROBE,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [6:0]          lfsr_q;
  logic [51:0]         used_q;
  logic [5:0]          probe_q;
  logic [5:0]          remaining_q;
  logic [CARD_W-1:0]   new_card_q;
  logic                add_player_q;
  logic                add_dealer_q;
  logic                busy_q;
  logic                target_player_q;  // 1: player hand, 0: dealer hand
  logic                is_deal_q;
  logic [1:0]          step_q;

  logic [6:0]          lfsr_d;
  logic [5:0]          start_probe_d;
  logic [5:0]          probe_inc_d;
  logic [CARD_W-1:0]   card_val_d;
  logic                any_draw_req;

  // x^7 + x^6 + 1 Fibonacci LFSR: maximal length, so a nonzero seed never
  // reaches the all-zero lock-up state.
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

`ifdef STACKED_DECK_EN
  assign start_probe_d = 6'd0;
`else
  // Fold the 64-value LFSR window onto the 52 deck slots.
  assign start_probe_d = (lfsr_q[5:0] >= 6'd52) ? (lfsr_q[5:0] - 6'd52) : lfsr_q[5:0];
`endif

  assign probe_inc_d = (probe_q == 6'd51) ? 6'd0 : (probe_q + 6'd1);

  // Blackjack value of a deck index. The ace counts as 1 here; the hand
  // controller decides whether to promote it to 11.
  function automatic logic [CARD_W-1:0] card_value(input logic [5:0] idx);
    logic [5:0] rank;
    logic [3:0] val;
    if (idx >= 6'd39)      rank = idx - 6'd39;
    else if (idx >= 6'd26) rank = idx - 6'd26;
    else if (idx >= 6'd13) rank = idx - 6'd13;
    else                   rank = idx;
    if (rank == 6'd0)      val = 4'd1;
    else if (rank <= 6'd9) val = rank[3:0] + 4'd1;
    else                   val = 4'd10;
    return CARD_W'(val);
  endfunction

  assign card_val_d   = card_value(probe_q);
  assign any_draw_req = i_deal_start | i_hit_player | i_hit_dealer;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      used_q          <= '0;
      probe_q         <= '0;
      remaining_q     <= 6'd52;
      new_card_q      <= '0;
      add_player_q    <= 1'b0;
      add_dealer_q    <= 1'b0;
      busy_q          <= 1'b0;
      target_player_q <= 1'b0;
      is_deal_q       <= 1'b0;
      step_q          <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          if (i_shuffle) begin
            used_q      <= '0;
            remaining_q <= 6'd52;
            lfsr_q      <= LFSR_SEED;
          end else if (any_draw_req && (remaining_q != 6'd0)) begin
            // Priority is deal > hit player > hit dealer. A deal always
            // starts with the player.
            target_player_q <= i_deal_start | i_hit_player;
            is_deal_q       <= i_deal_start;
            step_q          <= 2'd0;
            probe_q         <= start_probe_d;
            busy_q          <= 1'b1;
            state_q         <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          // Remaining is nonzero on entry, so a free slot always exists
          // within one lap of the deck.
          if (used_q[probe_q]) begin
            probe_q <= probe_inc_d;
          end else begin
            used_q[probe_q] <= 1'b1;
            remaining_q     <= remaining_q - 6'd1;
            new_card_q      <= card_val_d;
            state_q         <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          // The card value has now been stable for a full cycle; raise the
          // strobe so the hand side samples it on the strobe edge.
          add_player_q <= target_player_q;
          add_dealer_q <= ~target_player_q;
          state_q      <= S_STROBE;
        end

        S_STROBE: begin
          add_player_q <= 1'b0;
          add_dealer_q <= 1'b0;
          if (!is_deal_q || (remaining_q == 6'd0)) begin
            // A hit is complete, or the deal is aborted because the deck is empty.
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (step_q == 2'd3) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            step_q          <= step_q + 2'd1;
            target_player_q <= ~target_player_q;
            probe_q         <= start_probe_d;
            state_q         <= S_SEARCH;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_new_card        = new_card_q;
  assign o_add_player      = add_player_q;
  assign o_add_dealer      = add_dealer_q;
  assign o_busy            = busy_q;
  assign o_cards_remaining = remaining_q;
  assign o_deck_empty      = (remaining_q == 6'd0);

endmodule
